// File: rtl/vm_pkg.sv
// Shared types for the multi-item vending controller: coin codes, FSM states
// and the coin-to-units mapping.
package vm_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    U1   = 2'b01,
    U2   = 2'b10,
    U5   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_e;

  function automatic logic [2:0] coin_units(coin_e c);
    case (c)
      U1:      return 3'd1;
      U2:      return 3'd2;
      U5:      return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-panel / dispenser signal bundle. The panel side is the master,
// the vending controller is the slave.
interface vending_machine_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 4
);
  import vm_pkg::*;

  localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  coin_e                 coin;
  logic                  sel_valid;
  logic [ITEM_W-1:0]     sel;
  logic                  cancel;
  logic                  dispense;
  logic [ITEM_W-1:0]     dispense_item;
  logic                  change;
  logic                  coin_reject;
  logic [CREDIT_W-1:0]   credit;
  logic [NUM_ITEMS-1:0]  sold_out;
  logic                  busy;

  modport master (
    output coin, sel_valid, sel, cancel,
    input  dispense, dispense_item, change, coin_reject, credit, sold_out, busy
  );

  modport slave (
    input  coin, sel_valid, sel, cancel,
    output dispense, dispense_item, change, coin_reject, credit, sold_out, busy
  );

endinterface

// File: rtl/vm_stock.sv
// Per-item stock down-counters. A counter decrements only when selected by
// idx while dec is high, and never wraps below zero.
module vm_stock #(
  parameter int NUM_ITEMS  = 4,
  parameter int ITEM_W     = 2,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec,
  input  logic [ITEM_W-1:0]    idx,
  output logic [NUM_ITEMS-1:0] sold_out
);

  localparam logic [STOCK_W-1:0] INIT_C = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] ONE    = STOCK_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
      logic [STOCK_W-1:0] count_reg;
      logic               empty_reg;

      // The empty flag is registered alongside the count so sold_out changes
      // in the same cycle as the dispense pulse.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg <= INIT_C;
          empty_reg <= (INIT_C == '0);
        end else if (dec && (int'(idx) == gi) && (count_reg != '0)) begin
          count_reg <= count_reg - ONE;
          empty_reg <= (count_reg == ONE);
        end
      end

      assign sold_out[gi] = empty_reg;
    end
  endgenerate

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin collection with saturation check,
// stock-gated vending, and serial one-unit change/refund pulses.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input logic                    clk,
  input logic                    reset,
  vending_machine_multi_if.slave bus
);

  localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [CREDIT_W:0]   MAX_CREDIT_X = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE          = CREDIT_W'(1);

  state_e               state_reg;
  logic [CREDIT_W-1:0]  credit_reg;
  logic                 dispense_reg;
  logic [ITEM_W-1:0]    dispense_item_reg;
  logic                 change_reg;
  logic                 coin_reject_reg;
  logic                 busy_reg;
  logic [NUM_ITEMS-1:0] stock_empty;

  logic [CREDIT_W:0]    coin_sum;
  logic                 accepting;
  logic                 coin_present;
  logic                 sel_in_range;
  logic                 vend_ok;

  // One extra bit so an overflowing coin is detected instead of wrapping.
  assign coin_sum     = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_units(bus.coin));
  assign accepting    = (state_reg == IDLE) || (state_reg == COLLECT);
  assign coin_present = (bus.coin != NONE);
  assign sel_in_range = (int'(bus.sel) < NUM_ITEMS);
  assign vend_ok      = accepting && !bus.cancel && !coin_present && bus.sel_valid &&
                        (credit_reg >= PRICE_C) && sel_in_range && !stock_empty[bus.sel];

  vm_stock #(
    .NUM_ITEMS (NUM_ITEMS),
    .ITEM_W    (ITEM_W),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK)
  ) u_stock (
    .clk     (clk),
    .reset   (reset),
    .dec     (vend_ok),
    .idx     (bus.sel),
    .sold_out(stock_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      credit_reg        <= '0;
      dispense_reg      <= 1'b0;
      dispense_item_reg <= '0;
      change_reg        <= 1'b0;
      coin_reject_reg   <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      dispense_reg    <= 1'b0;
      change_reg      <= 1'b0;
      coin_reject_reg <= 1'b0;
      case (state_reg)
        IDLE, COLLECT: begin
          if (bus.cancel) begin
            // A coin arriving with cancel is dropped and handed back.
            coin_reject_reg <= coin_present;
            if (credit_reg != '0) begin
              state_reg  <= CHANGE;
              credit_reg <= credit_reg - ONE;
              change_reg <= 1'b1;
              busy_reg   <= 1'b1;
            end
          end else if (coin_present) begin
            if (coin_sum <= MAX_CREDIT_X) begin
              credit_reg <= coin_sum[CREDIT_W-1:0];
              state_reg  <= COLLECT;
            end else begin
              coin_reject_reg <= 1'b1;
            end
          end else if (vend_ok) begin
            credit_reg        <= credit_reg - PRICE_C;
            dispense_reg      <= 1'b1;
            dispense_item_reg <= bus.sel;
            state_reg         <= VEND;
            busy_reg          <= 1'b1;
          end
        end

        VEND, CHANGE: begin
          coin_reject_reg <= coin_present;
          if (credit_reg != '0) begin
            state_reg  <= CHANGE;
            credit_reg <= credit_reg - ONE;
            change_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dispense      = dispense_reg;
  assign bus.dispense_item = dispense_item_reg;
  assign bus.change        = change_reg;
  assign bus.coin_reject   = coin_reject_reg;
  assign bus.credit        = credit_reg;
  assign bus.sold_out      = stock_empty;
  assign bus.busy          = busy_reg;

endmodule
